multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle variant of the RV32I core. It sequences one instruction through FETCH/DECODE/EXEC/MEM/WB over a shared, variable-latency unified memory with a req/ack handshake.
- Drives the same datapath control fields the single-cycle decoder produces, but spread across states.
- Detects undefined opcodes and memory timeouts and parks the core in HALT.

Parameters:
- WAIT_MAX, 15, max cycles Mem_Req may stay high without Mem_Ack before a bus error; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- CLK  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- EN_PC  in  1  fetch enable; low holds FETCH without issuing a request
- Opcode  in  7  IR[6:0], valid from DECODE onward
- Mem_Ack  in  1  memory completion; read data valid in the same cycle
- Branch_Taken  in  1  branch compare result, valid in EXEC
- Mem_Req  out  1  memory request, held until Mem_Ack
- Mem_Wr_En  out  1  store strobe, qualified by Mem_Req
- Mem_Addr_Sel  out  1  0 = PC, 1 = ALU result
- IR_Wr_En  out  1  instruction register load
- PC_Wr_En  out  1  PC update strobe
- PC_Src  out  1  0 = PC+4, 1 = ALU target
- Reg_Wr_En  out  1  register file write
- Src_to_Reg  out  2  00 = ALU, 01 = memory, 10 = PC+4
- ALU_Src1_Sel  out  1  0 = rs1, 1 = PC
- ALU_Src2_Sel  out  1  0 = rs2, 1 = immediate
- Retire  out  1  one-cycle pulse per completed instruction
- Undef_Instr  out  1  sticky, set on an unknown opcode
- Bus_Err  out  1  sticky, set on a memory timeout
- Halted  out  1  high in HALT

Behaviour:
- Reset (async, rst_n=0): state=FETCH, class=NONE, wait counter=0. All outputs are 0 immediately, including Mem_Req mid-transaction.
- Outputs decode combinationally from registered state and latched class. IR_Wr_En is the only output that also depends on an input: IR_Wr_En = FETCH & Mem_Ack.
- FETCH:
  - If EN_PC=0: Mem_Req=0 and state holds.
  - Otherwise Mem_Req=1, Mem_Addr_Sel=0.
  - On Mem_Ack: IR_Wr_En=1, go to DECODE.
- DECODE (1 cycle): classify Opcode, using the codebase opcode values, into R, IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, and latch the class.
  - Unknown opcode: set Undef_Instr, go to HALT.
  - Otherwise go to EXEC.
- EXEC (1 cycle): {ALU_Src1_Sel, ALU_Src2_Sel} per class:
  - R = 00
  - IMM, LOAD, STORE, JALR, LUI = 01
  - BRANCH, JAL, AUIPC = 11
- EXEC next state:
  - LOAD/STORE go to MEM.
  - BRANCH: PC_Wr_En=1, PC_Src=Branch_Taken, Retire=1, go to FETCH.
  - All other classes go to WB.
- MEM:
  - Mem_Req=1, Mem_Addr_Sel=1, Mem_Wr_En=(class==STORE).
  - On Mem_Ack with STORE: PC_Wr_En=1, PC_Src=0, Retire=1, go to FETCH.
  - On Mem_Ack with LOAD: go to WB.
- WB (1 cycle): Reg_Wr_En=1, PC_Wr_En=1, Retire=1, go to FETCH. Per class:
  - Src_to_Reg = 01 for LOAD, 10 for JAL/JALR, else 00.
  - PC_Src = 1 for JAL/JALR, else 0.
- HALT: all strobes are 0 and Halted=1. Exit only via reset.
- Handshake rules:
  - Mem_Req, Mem_Addr_Sel and Mem_Wr_En stay stable until Mem_Ack.
  - Mem_Ack outside FETCH/MEM, or with EN_PC=0 in FETCH, is ignored.
  - Zero-wait ack (same cycle as the request) is legal.
- Wait counter:
  - Increments each cycle Mem_Req=1 and Mem_Ack=0; clears on Mem_Ack or on any state change.
  - If counter==WAIT_MAX and Mem_Ack=0 (with WAIT_MAX≠0): set Bus_Err, go to HALT. If Mem_Ack arrives in that same cycle, the ack wins.
  - The counter saturates and never wraps.
- Latency with zero-wait memory:
  - R/IMM/LUI/AUIPC/JAL/JALR = 4 cycles
  - LOAD = 5 cycles
  - STORE = 4 cycles
  - BRANCH = 3 cycles

Decomposition:
- Shared package/include rv32i_ctrl_pkg holds the opcode localparams, the state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT) and the class encoding. It is also used by the single-cycle decoder.
- One sub-module, rv_opcode_class: combinational Opcode to class plus valid flag.

Test Plan:
- Reset, EN_PC=1, ack every request in 0 waits, IR=0x00208033 (add) → IR_Wr_En at cycle 0, Reg_Wr_En=1 with Src_to_Reg=00 at cycle 3, Retire at cycle 3, next Mem_Req at cycle 4.
- LOAD (opcode 0x03) with a 3-cycle MEM ack → Mem_Addr_Sel=1 held for 4 cycles, then WB with Src_to_Reg=01; total 8 cycles.
- STORE (0x23) → Mem_Wr_En=1 only in MEM, Reg_Wr_En never asserts, Retire on the ack cycle.
- BRANCH (0x63): taken, then not taken → PC_Src=1 then 0, with PC_Wr_En in EXEC; 3 cycles each.
- Opcode 0x7F → Undef_Instr=1, Halted=1 from the next cycle; further acks are ignored until rst_n pulse clears everything.
- WAIT_MAX=15, no ack in FETCH → Bus_Err at the 16th request cycle. Second run: ack exactly at counter=15 → no error. Third run: rst_n low mid-request → Mem_Req drops asynchronously.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared RV32I control definitions: opcode values, multi-cycle FSM states and
// instruction classes. Also used by the single-cycle decoder.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } instr_class_t;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: maps IR[6:0] to an instruction class and
// flags opcodes the core does not implement.
module rv_opcode_class
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t op_class,
    output logic         valid
);

    always_comb begin
        op_class = CLS_NONE;
        valid    = 1'b1;
        case (opcode)
            OPC_R:      op_class = CLS_R;
            OPC_IMM:    op_class = CLS_IMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            default:    valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ack memory, with undefined-opcode and bus-timeout halting.
module multicycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       EN_PC,
    input  logic [6:0] Opcode,
    input  logic       Mem_Ack,
    input  logic       Branch_Taken,
    output logic       Mem_Req,
    output logic       Mem_Wr_En,
    output logic       Mem_Addr_Sel,
    output logic       IR_Wr_En,
    output logic       PC_Wr_En,
    output logic       PC_Src,
    output logic       Reg_Wr_En,
    output logic [1:0] Src_to_Reg,
    output logic       ALU_Src1_Sel,
    output logic       ALU_Src2_Sel,
    output logic       Retire,
    output logic       Undef_Instr,
    output logic       Bus_Err,
    output logic       Halted
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    ctrl_state_t        state;
    instr_class_t       cls;
    instr_class_t       dec_cls;
    logic               dec_valid;
    logic [CNT_W-1:0]   wait_cnt;
    logic               req_active;
    logic               timeout;

    rv_opcode_class u_opcode_class (
        .opcode   (Opcode),
        .op_class (dec_cls),
        .valid    (dec_valid)
    );

    assign req_active = ((state == ST_FETCH) && EN_PC) || (state == ST_MEM);
    assign timeout    = (WAIT_MAX != 0) && req_active && !Mem_Ack && (wait_cnt == WAIT_LIM);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            cls         <= CLS_NONE;
            wait_cnt    <= '0;
            Undef_Instr <= 1'b0;
            Bus_Err     <= 1'b0;
        end else begin
            // The counter is only nonzero while a request is pending, so
            // clearing it on ack/timeout also covers every state change.
            if (req_active) begin
                if (Mem_Ack || timeout)
                    wait_cnt <= '0;
                else if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + 1'b1;
            end

            if (timeout) begin
                Bus_Err <= 1'b1;
                state   <= ST_HALT;
            end else begin
                case (state)
                    ST_FETCH:
                        if (EN_PC && Mem_Ack) state <= ST_DECODE;
                    ST_DECODE:
                        if (dec_valid) begin
                            cls   <= dec_cls;
                            state <= ST_EXEC;
                        end else begin
                            Undef_Instr <= 1'b1;
                            state       <= ST_HALT;
                        end
                    ST_EXEC:
                        case (cls)
                            CLS_LOAD, CLS_STORE: state <= ST_MEM;
                            CLS_BRANCH:          state <= ST_FETCH;
                            default:             state <= ST_WB;
                        endcase
                    ST_MEM:
                        if (Mem_Ack) state <= (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                    ST_WB:
                        state <= ST_FETCH;
                    default:
                        state <= ST_HALT;
                endcase
            end
        end
    end

    always_comb begin
        Mem_Req      = 1'b0;
        Mem_Wr_En    = 1'b0;
        Mem_Addr_Sel = 1'b0;
        IR_Wr_En     = 1'b0;
        PC_Wr_En     = 1'b0;
        PC_Src       = 1'b0;
        Reg_Wr_En    = 1'b0;
        Src_to_Reg   = 2'b00;
        ALU_Src1_Sel = 1'b0;
        ALU_Src2_Sel = 1'b0;
        Retire       = 1'b0;
        Halted       = 1'b0;
        // Gated by rst_n so a pending request drops the moment reset asserts.
        if (rst_n) begin
            case (state)
                ST_FETCH:
                    if (EN_PC) begin
                        Mem_Req  = 1'b1;
                        IR_Wr_En = Mem_Ack;
                    end
                ST_EXEC: begin
                    case (cls)
                        CLS_R: ;
                        CLS_BRANCH, CLS_JAL, CLS_AUIPC: begin
                            ALU_Src1_Sel = 1'b1;
                            ALU_Src2_Sel = 1'b1;
                        end
                        default: ALU_Src2_Sel = 1'b1;
                    endcase
                    if (cls == CLS_BRANCH) begin
                        PC_Wr_En = 1'b1;
                        PC_Src   = Branch_Taken;
                        Retire   = 1'b1;
                    end
                end
                ST_MEM: begin
                    Mem_Req      = 1'b1;
                    Mem_Addr_Sel = 1'b1;
                    Mem_Wr_En    = (cls == CLS_STORE);
                    if (Mem_Ack && (cls == CLS_STORE)) begin
                        PC_Wr_En = 1'b1;
                        Retire   = 1'b1;
                    end
                end
                ST_WB: begin
                    Reg_Wr_En = 1'b1;
                    PC_Wr_En  = 1'b1;
                    Retire    = 1'b1;
                    if (cls == CLS_LOAD)
                        Src_to_Reg = 2'b01;
                    else if ((cls == CLS_JAL) || (cls == CLS_JALR)) begin
                        Src_to_Reg = 2'b10;
                        PC_Src     = 1'b1;
                    end
                end
                ST_HALT:
                    Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; outputs are packed as
// {Req,WrEn,AddrSel,IR}_{PCWr,PCSrc,RegWr}_{SrcToReg}_{A1,A2}_{Ret,Undef,BusErr,Halt}.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       EN_PC;
    logic [6:0] Opcode;
    logic       Mem_Ack;
    logic       Branch_Taken;
    logic       Mem_Req, Mem_Wr_En, Mem_Addr_Sel, IR_Wr_En, PC_Wr_En, PC_Src, Reg_Wr_En;
    logic [1:0] Src_to_Reg;
    logic       ALU_Src1_Sel, ALU_Src2_Sel, Retire, Undef_Instr, Bus_Err, Halted;
    logic [14:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .EN_PC        (EN_PC),
        .Opcode       (Opcode),
        .Mem_Ack      (Mem_Ack),
        .Branch_Taken (Branch_Taken),
        .Mem_Req      (Mem_Req),
        .Mem_Wr_En    (Mem_Wr_En),
        .Mem_Addr_Sel (Mem_Addr_Sel),
        .IR_Wr_En     (IR_Wr_En),
        .PC_Wr_En     (PC_Wr_En),
        .PC_Src       (PC_Src),
        .Reg_Wr_En    (Reg_Wr_En),
        .Src_to_Reg   (Src_to_Reg),
        .ALU_Src1_Sel (ALU_Src1_Sel),
        .ALU_Src2_Sel (ALU_Src2_Sel),
        .Retire       (Retire),
        .Undef_Instr  (Undef_Instr),
        .Bus_Err      (Bus_Err),
        .Halted       (Halted)
    );

    always #5 CLK = ~CLK;

    assign obs = {Mem_Req, Mem_Wr_En, Mem_Addr_Sel, IR_Wr_En, PC_Wr_En, PC_Src, Reg_Wr_En,
                  Src_to_Reg, ALU_Src1_Sel, ALU_Src2_Sel, Retire, Undef_Instr, Bus_Err, Halted};

    // Leaves the bench 1 time unit after a rising edge with the FSM in FETCH.
    task automatic apply_reset();
        rst_n = 1'b0;
        Mem_Ack = 1'b0;
        Branch_Taken = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EN_PC = 1'b1; Mem_Ack = 1'b1; Opcode = 7'h33;
        @(posedge CLK); @(posedge CLK); #4;
        n_cmp++;
        if (obs !== 15'b0) begin
            n_err++;
            $display("FAIL reset: got %b expected %b", obs, 15'b0);
        end
    endtask

    task automatic test_add();
        logic [14:0] exp_v [5] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0,
                                   15'b0000_101_00_00_1000, 15'b1000_000_00_00_0000};
        bit ack_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h33;
        for (int i = 0; i < 5; i++) begin
            Mem_Ack = ack_v[i];
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL add cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_jal();
        logic [14:0] exp_v [5] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0000_000_00_11_0000,
                                   15'b0000_111_10_00_1000, 15'b1000_000_00_00_0000};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h6F;
        for (int i = 0; i < 5; i++) begin
            Mem_Ack = (i == 0);
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL jal cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load();
        logic [14:0] exp_v [9] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0000_000_00_01_0000,
                                   15'b1010_000_00_00_0000, 15'b1010_000_00_00_0000,
                                   15'b1010_000_00_00_0000, 15'b1010_000_00_00_0000,
                                   15'b0000_101_01_00_1000, 15'b1000_000_00_00_0000};
        bit ack_v [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h03;
        for (int i = 0; i < 9; i++) begin
            Mem_Ack = ack_v[i];
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL load cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_store();
        logic [14:0] exp_v [6] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0000_000_00_01_0000,
                                   15'b1110_000_00_00_0000, 15'b1110_100_00_00_1000,
                                   15'b1000_000_00_00_0000};
        bit ack_v [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h23;
        for (int i = 0; i < 6; i++) begin
            Mem_Ack = ack_v[i];
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL store cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp_v [7] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0000_110_00_11_1000,
                                   15'b1001_000_00_00_0000, 15'b0, 15'b0000_100_00_11_1000,
                                   15'b1000_000_00_00_0000};
        bit ack_v [7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit taken_v [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h63;
        for (int i = 0; i < 7; i++) begin
            Mem_Ack = ack_v[i];
            Branch_Taken = taken_v[i];
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL branch cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_undef();
        logic [14:0] exp_v [5] = '{15'b1001_000_00_00_0000, 15'b0, 15'b0000_000_00_00_0101,
                                   15'b0000_000_00_00_0101, 15'b0000_000_00_00_0101};
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            Mem_Ack = 1'b1;
            #4;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++;
                $display("FAIL undef cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            @(posedge CLK); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 15'b0) begin
            n_err++;
            $display("FAIL undef reset clear: got %b expected %b", obs, 15'b0);
        end
        @(posedge CLK); #1;
        rst_n = 1'b1; Mem_Ack = 1'b0;
        #4;
        n_cmp++;
        if (obs !== 15'b1000_000_00_00_0000) begin
            n_err++;
            $display("FAIL undef restart: got %b expected %b", obs, 15'b1000_000_00_00_0000);
        end
    endtask

    task automatic test_timeout();
        logic [14:0] exp_v;
        apply_reset();
        EN_PC = 1'b1; Opcode = 7'h33;
        for (int i = 0; i < 18; i++) begin
            exp_v = (i < 16) ? 15'b1000_000_00_00_0000 : 15'b0000_000_00_00_0011;
            #4;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, exp_v);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_ack_at_limit();
        logic [14:0] exp_v;
        apply_reset();
        Opcode = 7'h33;
        // EN_PC low must not advance the wait counter.
        for (int i = 0; i < 22; i++) begin
            EN_PC   = (i >= 4);
            Mem_Ack = (i == 19);
            if (i < 4)       exp_v = 15'b0;
            else if (i < 19) exp_v = 15'b1000_000_00_00_0000;
            else if (i == 19) exp_v = 15'b1001_000_00_00_0000;
            else             exp_v = 15'b0;
            #4;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ack_at_limit cycle %0d: got %b expected %b", i, obs, exp_v);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        EN_PC = 1'b1; Mem_Ack = 1'b0; Opcode = 7'h33;
        @(posedge CLK); #5;
        n_cmp++;
        if (Mem_Req !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset pre: got %b expected %b", Mem_Req, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 15'b0) begin
            n_err++;
            $display("FAIL async_reset drop: got %b expected %b", obs, 15'b0);
        end
        @(posedge CLK); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; EN_PC = 1'b0; Opcode = '0; Mem_Ack = 1'b0; Branch_Taken = 1'b0;
        test_reset();
        test_add();
        test_jal();
        test_load();
        test_store();
        test_branch();
        test_undef();
        test_timeout();
        test_ack_at_limit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
